// File: rtl/axis_video_frame_aligner.sv
// AXI4-Stream video frame aligner: locks to SOF, regenerates TUSER/TLAST
// from its own pixel/line counters and counts framing errors.
module axis_video_frame_aligner #(
    parameter int DATA_WIDTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  S_AXIS_VIDEO_TUSER,
    input  logic                  S_AXIS_VIDEO_TLAST,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_VIDEO_TUSER,
    output logic                  M_AXIS_VIDEO_TLAST,
    output logic                  locked,
    output logic                  frame_done,
    output logic [ERR_W-1:0]      err_short,
    output logic [ERR_W-1:0]      err_long,
    output logic [ERR_W-1:0]      err_sof
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [1:0] {SEEK, PASS, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, ex;
    logic [YW-1:0] y_q, y_d, ey;
    logic          accept, take, fwd, frame_end;
    logic          last_pix, line_end, out_user, out_last;
    logic          inc_short, inc_long, inc_sof;

    assign S_AXIS_TREADY = !M_AXIS_TVALID | M_AXIS_TREADY;
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign locked        = (state_q != SEEK);

    // State and pixel/line position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEEK;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Per-beat decision: drop or forward, sideband regeneration, errors
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ex        = x_q;
        ey        = y_q;
        take      = 1'b0;
        fwd       = 1'b0;
        frame_end = 1'b0;
        last_pix  = 1'b0;
        line_end  = 1'b0;
        out_user  = 1'b0;
        out_last  = 1'b0;
        inc_short = 1'b0;
        inc_long  = 1'b0;
        inc_sof   = 1'b0;
        if (accept) begin
            unique case (state_q)
                SEEK: begin
                    take = S_AXIS_VIDEO_TUSER;
                    if (S_AXIS_VIDEO_TUSER) begin
                        ex = '0;
                        ey = '0;
                    end
                end
                PASS: begin
                    take = 1'b1;
                    if (S_AXIS_VIDEO_TUSER) begin
                        inc_sof = (x_q != '0) | (y_q != '0);
                        ex      = '0;
                        ey      = '0;
                    end
                end
                DRAIN: begin
                    if (S_AXIS_VIDEO_TUSER) begin
                        take    = 1'b1;
                        inc_sof = 1'b1;
                        ex      = '0;
                        ey      = '0;
                    end else if (S_AXIS_VIDEO_TLAST) begin
                        state_d = PASS;
                    end
                end
                default: state_d = SEEK;
            endcase
            if (take) begin
                fwd       = 1'b1;
                last_pix  = (ex == XW'(H_ACTIVE - 1));
                line_end  = S_AXIS_VIDEO_TLAST | last_pix;
                out_user  = (ex == '0) & (ey == '0);
                out_last  = line_end;
                inc_short = S_AXIS_VIDEO_TLAST & !last_pix;
                inc_long  = last_pix & !S_AXIS_VIDEO_TLAST;
                if (line_end) begin
                    x_d = '0;
                    if (ey == YW'(V_ACTIVE - 1)) begin
                        y_d       = '0;
                        frame_end = 1'b1;
                        state_d   = SEEK;
                    end else begin
                        y_d     = ey + 1'b1;
                        state_d = inc_long ? DRAIN : PASS;
                    end
                end else begin
                    x_d     = ex + 1'b1;
                    y_d     = ey;
                    state_d = PASS;
                end
            end
        end
    end

    // Registered output slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_AXIS_TDATA       <= '0;
            M_AXIS_TVALID      <= 1'b0;
            M_AXIS_VIDEO_TUSER <= 1'b0;
            M_AXIS_VIDEO_TLAST <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            frame_done <= fwd & frame_end;
            if (fwd) begin
                M_AXIS_TDATA       <= S_AXIS_TDATA;
                M_AXIS_TVALID      <= 1'b1;
                M_AXIS_VIDEO_TUSER <= out_user;
                M_AXIS_VIDEO_TLAST <= out_last;
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
        end
    end

    // Saturating framing-error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_short <= '0;
            err_long  <= '0;
            err_sof   <= '0;
        end else begin
            if (inc_short && err_short != '1) err_short <= err_short + 1'b1;
            if (inc_long && err_long != '1)   err_long  <= err_long + 1'b1;
            if (inc_sof && err_sof != '1)     err_sof   <= err_sof + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_video_frame_aligner.sv
// Scoreboard bench for axis_video_frame_aligner (H_ACTIVE=4, V_ACTIVE=2).
// Driver feeds a frame-level reference model; monitor checks M_AXIS beats.
module tb_axis_video_frame_aligner;

    localparam int DW = 16;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_user = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_user;
    logic          m_last;
    logic          locked;
    logic          frame_done;
    logic [EW-1:0] err_short;
    logic [EW-1:0] err_long;
    logic [EW-1:0] err_sof;

    axis_video_frame_aligner #(
        .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .ERR_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .S_AXIS_TDATA(s_data),
        .S_AXIS_TVALID(s_valid),
        .S_AXIS_TREADY(s_ready),
        .S_AXIS_VIDEO_TUSER(s_user),
        .S_AXIS_VIDEO_TLAST(s_last),
        .M_AXIS_TDATA(m_data),
        .M_AXIS_TVALID(m_valid),
        .M_AXIS_TREADY(m_ready),
        .M_AXIS_VIDEO_TUSER(m_user),
        .M_AXIS_VIDEO_TLAST(m_last),
        .locked(locked),
        .frame_done(frame_done),
        .err_short(err_short),
        .err_long(err_long),
        .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW+1:0] exp_q[$];

    // Reference model: 0 = hunting for SOF, 1 = in frame, 2 = skipping tail
    int mode = 0;
    int px = 0;
    int py = 0;
    int n_short = 0;
    int n_long = 0;
    int n_sof = 0;
    int n_fd = 0;
    int fd_seen = 0;

    int rmode = 0;
    int phase = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp_v, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << EW) - 1) ? (1 << EW) - 1 : v + 1;
    endfunction

    // Apply one accepted input beat to the frame-level model
    function automatic void model_beat(input logic [DW-1:0] d,
                                       input logic u, input logic l);
        bit sol;
        bit eol;
        if (mode == 0 && !u) return;
        if (mode == 2 && !u) begin
            if (l) mode = 1;
            return;
        end
        if (u) begin
            if (mode == 2 || (mode == 1 && (px != 0 || py != 0)))
                n_sof = sat(n_sof);
            px = 0;
            py = 0;
        end
        sol = (px == 0 && py == 0);
        eol = l || (px == H - 1);
        exp_q.push_back({d, sol, eol});
        if (l && px != H - 1) n_short = sat(n_short);
        if (!l && px == H - 1) n_long = sat(n_long);
        if (eol) begin
            if (py == V - 1) begin
                px = 0;
                py = 0;
                mode = 0;
                n_fd++;
            end else begin
                mode = (!l) ? 2 : 1;
                px = 0;
                py++;
            end
        end else begin
            px++;
            mode = 1;
        end
    endfunction

    // One cycle: drive inputs after the falling edge, check, record accepts
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic u, input logic l, output bit acc);
        @(negedge clk);
        case (rmode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (phase != 0);
                phase = (phase + 1) % 3;
            end
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        s_valid = v;
        s_data  = d;
        s_user  = u;
        s_last  = l;
        #1;
        chk("locked", int'(locked), int'(mode != 0));
        chk("s_ready", int'(s_ready), int'(!m_valid || m_ready));
        acc = v && s_ready;
        if (acc) model_beat(d, u, l);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++)
            step(1'b0, DW'($urandom), 1'($urandom), 1'($urandom), a);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic u,
                        input logic l);
        bit a;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, d, u, l, a);
            if (a) return;
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic clean_frame(input int base);
        for (int i = 0; i < H * V; i++)
            send(DW'(base + i), i == 0, (i % H) == H - 1);
    endtask

    task automatic check_counts(input string tag);
        idle(4);
        chk({tag, "_err_short"}, int'(err_short), n_short);
        chk({tag, "_err_long"}, int'(err_long), n_long);
        chk({tag, "_err_sof"}, int'(err_sof), n_sof);
        chk({tag, "_frame_done"}, fd_seen, n_fd);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_m_user"}, int'(m_user), 0);
        chk({tag, "_m_last"}, int'(m_last), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_errs"}, int'({err_short, err_long, err_sof}), 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        mode = 0;
        px = 0;
        py = 0;
        n_short = 0;
        n_long = 0;
        n_sof = 0;
        n_fd = 0;
        fd_seen = 0;
    endtask

    // Monitor: pop and compare on every output handshake, check stall hold
    logic [DW+1:0] held;
    bit            stalled = 1'b0;
    initial begin
        logic [DW+1:0] cur;
        logic [DW+1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                cur = {m_data, m_user, m_last};
                if (frame_done) fd_seen++;
                if (stalled) chk("stall_hold", int'(cur), int'(held));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", int'(cur), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", int'(cur), int'(e));
                    end
                end
                stalled = m_valid && !m_ready;
                held = cur;
            end
        end
    end

    initial begin
        int gx;
        int gy;
        logic u;
        logic l;
        bit a;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_s_ready", int'(s_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Clean frame
        clean_frame(1);
        check_counts("clean");

        // Garbage then a clean frame
        for (int i = 0; i < 3; i++) send(DW'(16'h00a0 + i), 1'b0, 1'b0);
        clean_frame(1);
        check_counts("garbage");

        // Short line 0
        send(16'h0011, 1'b1, 1'b0);
        send(16'h0012, 1'b0, 1'b0);
        send(16'h0013, 1'b0, 1'b1);
        for (int i = 0; i < H; i++)
            send(DW'(16'h0014 + i), 1'b0, i == H - 1);
        check_counts("short");

        // Long line 0 (6 pixels), then a normal line 1
        for (int i = 0; i < 6; i++)
            send(DW'(16'h0021 + i), i == 0, i == 5);
        for (int i = 0; i < H; i++)
            send(DW'(16'h0031 + i), 1'b0, i == H - 1);
        check_counts("long");

        // Backpressure 1-of-3
        rmode = 1;
        clean_frame(16'h0041);
        check_counts("stall");
        rmode = 0;

        // Reset mid line 1
        for (int i = 0; i < H + 2; i++)
            send(DW'(16'h0051 + i), i == 0, (i % H) == H - 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        send(16'h0061, 1'b0, 1'b0);
        send(16'h0062, 1'b0, 1'b1);
        clean_frame(16'h0071);
        check_counts("relock");

        // Randomized mostly-well-formed traffic with perturbations
        rmode = 2;
        gx = 0;
        gy = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            u = (gx == 0 && gy == 0) ? ($urandom_range(0, 9) != 0)
                                     : ($urandom_range(0, 29) == 0);
            l = (gx == H - 1) ? ($urandom_range(0, 9) != 0)
                              : ($urandom_range(0, 14) == 0);
            send(DW'($urandom), u, l);
            if (u) begin
                gx = 0;
                gy = 0;
            end
            if (l || gx >= H + 1) begin
                gx = 0;
                gy = (gy + 1) % V;
            end else begin
                gx++;
            end
        end
        rmode = 0;
        check_counts("random");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
